id_issue: RTL
=============

# id_issue

Parametrised decode-and-issue stage between IF and EX. It decodes one RV32I instruction per cycle, resolves both source operands from the register file or from `NUM_FWD` prioritised forwarding channels, and detects load-use hazards across every channel. The result is held in a registered ID/EX slot with valid/ready handshakes on both sides, plus flush support and a stall-cycle counter.

## Interface

- `XLEN`, 32: data and PC width.
- `NUM_FWD`, 2: forwarding channels; channel 0 is the youngest and has the highest priority.
- `CNT_W`, 32: stall counter width.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: IF offers an instruction.
- `in_ready` out 1: instruction accepted this cycle.
- `in_pc` in XLEN: PC of the offered instruction.
- `in_inst` in 32: instruction word.
- `rf_raddr1`, `rf_raddr2` out 5: register-file read addresses (combinational).
- `rf_rdata1`, `rf_rdata2` in XLEN: register-file read data (same cycle).
- `fwd_wreg` in NUM_FWD: channel k writes a register.
- `fwd_wd` in 5*NUM_FWD: destination register of channel k, at bits [5k+4:5k].
- `fwd_wdata` in XLEN*NUM_FWD: result of channel k.
- `fwd_pending` in NUM_FWD: channel k result is not yet available (load in flight).
- `flush` in 1: squash the slot and the offered instruction.
- `out_valid` out 1: the ID/EX slot holds an instruction.
- `out_ready` in 1: EX consumes the slot.
- `out_pc`, `out_rs1_val`, `out_rs2_val`, `out_imm` out XLEN: slot payload.
- `out_opcode` out 7, `out_func3` out 3, `out_func7` out 7, `out_wd` out 5, `out_wreg` out 1: slot payload.
- `out_illegal` out 1: opcode not in the supported set.
- `stall_req` out 1: load-use hazard this cycle (combinational).
- `stall_cycles` out CNT_W: saturating hazard-cycle count.

## Operation

- **Supported opcodes:** LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
- **Unsupported opcodes:** `out_opcode`=0, `out_wreg`=0, `out_illegal`=1. The instruction still occupies the slot.
- **Immediates:**
  - I, S, B and J types are sign-extended to XLEN. B and J have bit 0 forced to 0.
  - U type is {inst[31:12], 12'b0}.
  - SLLI, SRLI and SRAI give `out_imm` = {0, inst[24:20]}. `out_func7` carries inst[31:25].
- **Register reads:**
  - rs1 is read for JALR, BRANCH, LOAD, STORE, OP_IMM and OP.
  - rs2 is read for BRANCH, STORE and OP.
  - An unread operand is driven as 0.
- **Write enable:** `out_wreg`=1 for LUI, AUIPC, JAL, JALR, LOAD, OP_IMM and OP.
- **Writes to x0:** if rd=x0, `out_wreg` is forced to 0.
- **Operand resolution, per read source with address a:**
  - If a=0, the value is 0. Forwarding and hazard logic are ignored.
  - Otherwise scan channels k=0..NUM_FWD-1 and take the first k with `fwd_wreg[k]` and `fwd_wd[k]`==a.
  - If that channel has `fwd_pending[k]`=1, it is a hazard. Otherwise the value is `fwd_wdata[k]`.
  - If no channel matches, the value is `rf_rdata`.
  - An older matching channel is never used when a younger one matches.
- **Hazard:** `stall_req` = `in_valid` & (hazard on either source) & !`flush`.
- **Ready:** `in_ready` = !`flush` & !hazard & (!`out_valid` | `out_ready`).
- **Slot update at each edge, in priority order:**
  1. `flush` clears `out_valid`.
  2. Otherwise, if `in_valid` & `in_ready`, load the slot and set `out_valid`=1.
  3. Otherwise, if `out_ready`, clear `out_valid`.
  4. Otherwise hold.
- **Payload while not valid:** payload registers hold their last value; only `out_valid` is meaningful.
- **Counter:** `stall_cycles` increments on each cycle with `stall_req`=1 and saturates at all-ones. It is not cleared by `flush`.

## Timing

- **Reset:** `out_valid`=0, every payload output=0, `out_illegal`=0, `stall_cycles`=0. An asynchronous assertion mid-transfer drops the slot contents immediately.
- **Combinational outputs:** `rf_raddr1`=inst[19:15] and `rf_raddr2`=inst[24:20], combinational from `in_inst`.
- **Latency:** 1 cycle, from the accepting edge to `out_valid`=1.
- **Throughput:** 1 instruction per cycle when `out_ready`=1.
- **Hazard release:** when `fwd_pending` falls (or the producer leaves all channels), `in_ready` rises in that same cycle. The instruction is accepted with the forwarded or RF value at that edge; there is no extra bubble cycle.
- **Backpressure:** with `out_valid`=1 and `out_ready`=0, `in_ready`=0 and the slot is stable.
- **Flush + `in_valid`:** nothing is captured and `out_valid`=0 next cycle.
- **Flush + hazard:** no counter increment.

## Test plan

- **Immediate decode:** reset, then `in_inst`=0x00500093 (addi x1,x0,5) at pc 0x100 -> one cycle later `out_valid`=1, `out_imm`=5, `out_wd`=1, `out_wreg`=1, `out_rs1_val`=0, `out_pc`=0x100.
- **Forwarding priority:** `in_inst`=0x002081B3 (add x3,x1,x2) with ch0 wd=1 data 0xAA, ch1 wd=1 data 0xBB, RF x2=7 -> `out_rs1_val`=0xAA, `out_rs2_val`=7.
- **Load-use stall:** `in_inst`=0x00528333 (add x6,x5,x5) with ch0 wd=5 pending=1 for 3 cycles -> `stall_req`=1 and `in_ready`=0 for 3 cycles, `stall_cycles`=3. On the next cycle, data 0x1234 with pending=0 -> accepted, both operands 0x1234.
- **Shift and illegal decode:** 0x4030D393 (srai x7,x1,3) -> `out_imm`=3, `out_func7`=0x20. Then 0x0000007F -> `out_illegal`=1, `out_wreg`=0.
- **Backpressure and flush:** JAL 0x008000EF accepted with `out_ready`=0 for 2 cycles -> slot stable, `out_imm`=8, `in_ready`=0. Then `flush`=1 -> `out_valid`=0 next cycle, offered instruction dropped.
- **Reset mid-operation:** `rst` low mid-stream -> all outputs are immediately 0 including `stall_cycles`. Also drive ch0 wd=0 with pending=1 against rs1=x0 -> no stall.

Source files
------------

// File: rtl/id_issue_if.sv
// id_issue_if: the IF offer, register-file read, forwarding and ID/EX slot signals of id_issue.
// The slave modport is the issue stage itself; master is the surrounding pipeline.
interface id_issue_if #(
    parameter int XLEN = 32,
    parameter int NUM_FWD = 2,
    parameter int CNT_W = 32
);
    logic                    in_valid, in_ready;
    logic [XLEN-1:0]         in_pc;
    logic [31:0]             in_inst;
    logic [4:0]              rf_raddr1, rf_raddr2;
    logic [XLEN-1:0]         rf_rdata1, rf_rdata2;
    logic [NUM_FWD-1:0]      fwd_wreg, fwd_pending;
    logic [5*NUM_FWD-1:0]    fwd_wd;
    logic [XLEN*NUM_FWD-1:0] fwd_wdata;
    logic                    flush;
    logic                    out_valid, out_ready;
    logic [XLEN-1:0]         out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [6:0]              out_opcode, out_func7;
    logic [2:0]              out_func3;
    logic [4:0]              out_wd;
    logic                    out_wreg, out_illegal, stall_req;
    logic [CNT_W-1:0]        stall_cycles;

    modport slave (
        input  in_valid, in_pc, in_inst, rf_rdata1, rf_rdata2, fwd_wreg, fwd_wd, fwd_wdata,
               fwd_pending, flush, out_ready,
        output in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_rs1_val, out_rs2_val,
               out_imm, out_opcode, out_func3, out_func7, out_wd, out_wreg, out_illegal,
               stall_req, stall_cycles
    );

    modport master (
        output in_valid, in_pc, in_inst, rf_rdata1, rf_rdata2, fwd_wreg, fwd_wd, fwd_wdata,
               fwd_pending, flush, out_ready,
        input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_rs1_val, out_rs2_val,
               out_imm, out_opcode, out_func3, out_func7, out_wd, out_wreg, out_illegal,
               stall_req, stall_cycles
    );
endinterface

// File: rtl/id_issue.sv
// id_issue: RV32I decode-and-issue stage with prioritised operand forwarding,
// load-use hazard detection and a registered ID/EX slot.
module id_issue #(
    parameter int XLEN = 32,
    parameter int NUM_FWD = 2,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst,
    id_issue_if.slave b
);
    logic [31:0]     inst;
    logic [6:0]      op;
    logic            is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
    logic            legal, use1, use2, wr, shift;
    logic [XLEN-1:0] imm, v1, v2;
    logic            hz1, hz2, hz;

    assign inst     = b.in_inst;
    assign op       = inst[6:0];
    assign is_lui   = op == 7'b0110111;
    assign is_auipc = op == 7'b0010111;
    assign is_jal   = op == 7'b1101111;
    assign is_jalr  = op == 7'b1100111;
    assign is_br    = op == 7'b1100011;
    assign is_ld    = op == 7'b0000011;
    assign is_st    = op == 7'b0100011;
    assign is_opi   = op == 7'b0010011;
    assign is_op    = op == 7'b0110011;
    assign legal    = is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st | is_opi | is_op;
    assign use1     = is_jalr | is_br | is_ld | is_st | is_opi | is_op;
    assign use2     = is_br | is_st | is_op;
    assign wr       = (is_lui | is_auipc | is_jal | is_jalr | is_ld | is_opi | is_op) && inst[11:7] != 5'd0;
    // func3 001 (SLLI) and 101 (SRLI/SRAI) carry a shamt instead of an I immediate
    assign shift    = is_opi && inst[13:12] == 2'b01;

    assign b.rf_raddr1 = inst[19:15];
    assign b.rf_raddr2 = inst[24:20];

    always_comb
        imm = (is_lui | is_auipc) ? {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0} :
              is_jal ? {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0} :
              is_br ? {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0} :
              is_st ? {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]} :
              shift ? {{(XLEN-5){1'b0}}, inst[24:20]} :
              (is_jalr | is_ld | is_opi) ? {{(XLEN-12){inst[31]}}, inst[31:20]} : '0;

    // Walk oldest to youngest so the youngest matching channel overrides.
    always_comb begin
        hz1 = 1'b0;
        v1  = b.rf_rdata1;
        hz2 = 1'b0;
        v2  = b.rf_rdata2;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (b.fwd_wreg[k] && b.fwd_wd[5*k +: 5] == inst[19:15]) begin
                hz1 = b.fwd_pending[k];
                v1  = b.fwd_wdata[XLEN*k +: XLEN];
            end
            if (b.fwd_wreg[k] && b.fwd_wd[5*k +: 5] == inst[24:20]) begin
                hz2 = b.fwd_pending[k];
                v2  = b.fwd_wdata[XLEN*k +: XLEN];
            end
        end
        if (!use1 || inst[19:15] == 5'd0) begin
            hz1 = 1'b0;
            v1  = '0;
        end
        if (!use2 || inst[24:20] == 5'd0) begin
            hz2 = 1'b0;
            v2  = '0;
        end
    end

    assign hz          = hz1 | hz2;
    assign b.in_ready  = !b.flush && !hz && (!b.out_valid || b.out_ready);
    assign b.stall_req = b.in_valid && hz && !b.flush;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            b.out_valid    <= 1'b0;
            b.out_pc       <= '0;
            b.out_rs1_val  <= '0;
            b.out_rs2_val  <= '0;
            b.out_imm      <= '0;
            b.out_opcode   <= '0;
            b.out_func3    <= '0;
            b.out_func7    <= '0;
            b.out_wd       <= '0;
            b.out_wreg     <= 1'b0;
            b.out_illegal  <= 1'b0;
            b.stall_cycles <= '0;
        end else begin
            if (b.flush)
                b.out_valid <= 1'b0;
            else if (b.in_valid && b.in_ready) begin
                b.out_valid   <= 1'b1;
                b.out_pc      <= b.in_pc;
                b.out_rs1_val <= v1;
                b.out_rs2_val <= v2;
                b.out_imm     <= imm;
                b.out_opcode  <= legal ? op : 7'd0;
                b.out_func3   <= inst[14:12];
                b.out_func7   <= inst[31:25];
                b.out_wd      <= inst[11:7];
                b.out_wreg    <= wr;
                b.out_illegal <= !legal;
            end else if (b.out_ready)
                b.out_valid <= 1'b0;
            if (b.stall_req && !(&b.stall_cycles))
                b.stall_cycles <= b.stall_cycles + CNT_W'(1);
        end
endmodule
